// File: rtl/sc_inference_ctrl_if.sv
// rtl/sc_inference_ctrl_if.sv - host, network and result signal bundle for sc_inference_ctrl
interface sc_inference_ctrl_if #(
  parameter int N2 = 10,
  parameter int CW = 9,
  parameter int IW = 4
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          net_clear;
  logic          sng_en;
  logic [N2-1:0] net_dout;
  logic [N2*CW-1:0] counts;
  logic [IW-1:0] pred;
  logic          result_valid;
  logic          result_ready;

  modport master (
    output start, abort, net_dout, result_ready,
    input  busy, net_clear, sng_en, counts, pred, result_valid
  );

  modport slave (
    input  start, abort, net_dout, result_ready,
    output busy, net_clear, sng_en, counts, pred, result_valid
  );
endinterface

// File: rtl/sc_inference_ctrl.sv
// rtl/sc_inference_ctrl.sv - stochastic-computing inference sequencer; SC_CTRL_ARGMAX_EN adds argmax
module sc_inference_ctrl #(
  parameter int N2         = 10,
  parameter int STREAM_LEN = 256,
  parameter int WARMUP     = 2,
  parameter int CLR_CYCLES = 2,
  parameter int CW         = $clog2(STREAM_LEN + 1),
  parameter int IW         = (N2 > 1) ? $clog2(N2) : 1
) (
  input logic             clk,
  input logic             reset,
  sc_inference_ctrl_if.slave bus
);

  localparam logic [31:0] CLR_LAST  = 32'(CLR_CYCLES - 1);
  localparam logic [31:0] WARM_LAST = (WARMUP > 0) ? 32'(WARMUP - 1) : 32'd0;
  localparam logic [31:0] RUN_LAST  = 32'(STREAM_LEN - 1);

`ifdef SC_CTRL_ARGMAX_EN
  localparam logic [31:0] ARG_LAST  = 32'(N2 - 1);
  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE, ARGMAX} state_t;
`else
  typedef enum logic [2:0] {IDLE, CLEAR, WARM, RUN, DONE} state_t;
`endif

  state_t          state, state_d;
  logic [31:0]     cnt, cnt_d;
  logic            busy_q, net_clear_q, sng_en_q, result_valid_q;
  logic [N2*CW-1:0] counts_q;
  logic            clear_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 32'd1;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (bus.start && !bus.abort) state_d = CLEAR;
      end
      CLEAR: if (cnt == CLR_LAST) begin
        cnt_d   = '0;
        state_d = (WARMUP == 0) ? RUN : WARM;
      end
      WARM: if (cnt == WARM_LAST) begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: if (cnt == RUN_LAST) begin
        cnt_d   = '0;
`ifdef SC_CTRL_ARGMAX_EN
        state_d = ARGMAX;
`else
        state_d = DONE;
`endif
      end
`ifdef SC_CTRL_ARGMAX_EN
      ARGMAX: if (cnt == ARG_LAST) begin
        cnt_d   = '0;
        state_d = DONE;
      end
`endif
      DONE: begin
        cnt_d = '0;
        if (result_valid_q && bus.result_ready) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // abort outranks every other input once an inference is under way
    if (bus.abort && state != IDLE) begin
      cnt_d   = '0;
      state_d = IDLE;
    end
  end

  assign clear_cnt = (state == IDLE && state_d == CLEAR) || (state != IDLE && bus.abort);

  // Outputs are decoded from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q         <= 1'b0;
      net_clear_q    <= 1'b0;
      sng_en_q       <= 1'b0;
      result_valid_q <= 1'b0;
      counts_q       <= '0;
    end else begin
      busy_q         <= (state_d != IDLE);
      net_clear_q    <= (state_d == CLEAR);
      sng_en_q       <= (state_d == WARM) || (state_d == RUN);
      result_valid_q <= (state_d == DONE);
      if (clear_cnt) begin
        counts_q <= '0;
      end else if (state == RUN) begin
        for (int k = 0; k < N2; k++)
          counts_q[k*CW +: CW] <= counts_q[k*CW +: CW] + CW'(bus.net_dout[k]);
      end
    end
  end

`ifdef SC_CTRL_ARGMAX_EN
  logic [CW-1:0] cur, best;
  logic [IW-1:0] pred_q;

  always_comb begin
    cur = '0;
    for (int k = 0; k < N2; k++)
      if (cnt == 32'(k)) cur = counts_q[k*CW +: CW];
  end

  // Strict compare keeps the lowest index on ties; class 0 seeds the search
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best   <= '0;
      pred_q <= '0;
    end else if (clear_cnt) begin
      best   <= '0;
      pred_q <= '0;
    end else if (state == ARGMAX && (cnt == 32'd0 || cur > best)) begin
      best   <= cur;
      pred_q <= cnt[IW-1:0];
    end
  end

  assign bus.pred = pred_q;
`else
  assign bus.pred = '0;
`endif

  assign bus.busy         = busy_q;
  assign bus.net_clear    = net_clear_q;
  assign bus.sng_en       = sng_en_q;
  assign bus.result_valid = result_valid_q;
  assign bus.counts       = counts_q;

endmodule

// File: tb/tb_sc_inference_ctrl.sv
// tb/tb_sc_inference_ctrl.sv - randomized self-checking bench for sc_inference_ctrl
module tb_sc_inference_ctrl;
  localparam int N2 = 2;
  localparam int L  = 8;
  localparam int W  = 2;
  localparam int C  = 2;
  localparam int CW = 4;
  localparam int IW = 1;
`ifdef SC_CTRL_ARGMAX_EN
  localparam int RV = C + W + L + N2 + 1;
`else
  localparam int RV = C + W + L + 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [1:0] pat [1:64];

  always #5 clk = ~clk;

  sc_inference_ctrl_if #(.N2(N2), .CW(CW), .IW(IW)) bus ();

  sc_inference_ctrl #(
    .N2(N2), .STREAM_LEN(L), .WARMUP(W), .CLR_CYCLES(C), .CW(CW), .IW(IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".net_clear"}, 32'(bus.net_clear), 0);
    check({tag, ".sng_en"}, 32'(bus.sng_en), 0);
    check({tag, ".result_valid"}, 32'(bus.result_valid), 0);
  endtask

  task automatic randomize_pat();
    for (int c = 1; c <= 64; c++) pat[c] = 2'($urandom);
  endtask

  // Reference: counts are the ones over the RUN window of the timeline; argmax favours the lowest index
  task automatic run_inf(input string tag, input int abort_cyc, input int stall, input int start_cyc);
    int exp_cnt [N2];
    int exp_pred;
    int last;
    for (int k = 0; k < N2; k++) exp_cnt[k] = 0;
    for (int c = C + W + 1; c <= C + W + L; c++)
      for (int k = 0; k < N2; k++) exp_cnt[k] += int'(pat[c][k]);
    exp_pred = 0;
`ifdef SC_CTRL_ARGMAX_EN
    for (int k = 1; k < N2; k++) if (exp_cnt[k] > exp_cnt[exp_pred]) exp_pred = k;
`endif
    last = (abort_cyc > 0) ? abort_cyc + 1 : RV + stall + 2;

    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      bus.net_dout     = pat[cyc];
      bus.abort        = (cyc == abort_cyc);
      bus.result_ready = (cyc >= RV + stall);
      bus.start        = (cyc == start_cyc);
      @(negedge clk);
      if (abort_cyc > 0 && cyc > abort_cyc) begin
        check_idle({tag, ".abort"});
        for (int k = 0; k < N2; k++)
          check({tag, ".abort.counts"}, 32'(bus.counts[k*CW +: CW]), 0);
      end else begin
        check({tag, ".net_clear"}, 32'(bus.net_clear), 32'(cyc <= C));
        check({tag, ".sng_en"}, 32'(bus.sng_en), 32'(cyc > C && cyc <= C + W + L));
        check({tag, ".busy"}, 32'(bus.busy), 32'(cyc <= RV + stall));
        check({tag, ".result_valid"}, 32'(bus.result_valid), 32'(cyc >= RV && cyc <= RV + stall));
        if (cyc >= RV) begin
          for (int k = 0; k < N2; k++)
            check({tag, ".counts"}, 32'(bus.counts[k*CW +: CW]), 32'(exp_cnt[k]));
          check({tag, ".pred"}, 32'(bus.pred), 32'(exp_pred));
        end
      end
      @(posedge clk);
      #1;
    end
    bus.abort        = 1'b0;
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.net_dout     = '0;
    bus.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset.counts", 32'(bus.counts), 0);
    check("reset.pred", 32'(bus.pred), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int c = 1; c <= 64; c++) pat[c] = 2'b01;
    run_inf("basic", 0, 0, 0);

    for (int c = 1; c <= 64; c++) pat[c] = (c == 3 || c == 4) ? 2'b11 : 2'b00;
    run_inf("warmup", 0, 0, 0);

    randomize_pat();
    for (int i = 0; i < L; i++) begin
      pat[C + W + 1 + i][0] = (i >= 3);
      pat[C + W + 1 + i][1] = (i < 5);
    end
    run_inf("tie55", 0, 0, 0);
    for (int i = 0; i < L; i++) pat[C + W + 1 + i][1] = (i < 6);
    run_inf("tie56", 0, 0, 0);

    randomize_pat();
    run_inf("backpressure", 0, 20, RV + 10);

    randomize_pat();
    run_inf("abort", 7, 0, 0);
    randomize_pat();
    run_inf("after_abort", 0, 0, 0);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check_idle("abort_start_idle");
    @(posedge clk);
    #1;

    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("warm.sng_en", 32'(bus.sng_en), 1);
    #2 reset = 1'b0;
    #1;
    check_idle("async_reset");
    check("async_reset.counts", 32'(bus.counts), 0);
    check("async_reset.pred", 32'(bus.pred), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    randomize_pat();
    run_inf("after_reset", 0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      int st;
      randomize_pat();
      st = int'($urandom_range(0, 4));
      run_inf("random", 0, st, RV + st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sc_inference_ctrl.md
# sc_inference_ctrl

Sequencing controller for the stochastic-computing MNIST classifier datapath. It clears the APC-neuron network and its stochastic number generators, enables bitstream generation for a fixed stream length, and discards the pipeline-fill bits. It then accumulates the ones-count of every output bitstream and presents the counts, and optionally the winning class, through a valid/ready result handshake. It sits between the host/test harness and the network plus its SNG bank.

## Interface
- `N2`, 10, number of network outputs (classes) counted.
- `STREAM_LEN`, 256, bitstream cycles counted per inference; ≥ 1.
- `WARMUP`, 2, cycles with SNGs enabled but output bits discarded (network fill); ≥ 0.
- `CLR_CYCLES`, 2, cycles `net_clear` is held high; ≥ 1.
- `CW`, `$clog2(STREAM_LEN+1)`, per-output counter width.
- `IW`, `$clog2(N2)` (min 1), class index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request an inference; honoured only in IDLE.
- `abort` in 1: cancel the current inference; has priority over all other inputs.
- `busy` out 1: high in every state except IDLE.
- `net_clear` out 1: active-high clear to the network neurons and SNG seed load.
- `sng_en` out 1: SNG/bitstream advance enable.
- `net_dout` in N2: network output bitstreams, one bit per class per cycle.
- `counts` out N2*CW: ones-count per class; class k is at bits [k*CW +: CW].
- `pred` out IW: argmax class index (only with the macro; otherwise tied 0).
- `result_valid` out 1: counts/pred are valid.
- `result_ready` in 1: consumer accepts the result.

## Operation
- FSM states: IDLE, CLEAR, WARM, RUN, ARGMAX (macro only), DONE.
- Transitions:
  - IDLE→CLEAR on `start`.
  - CLEAR→WARM after `CLR_CYCLES` cycles. With `WARMUP=0`, CLEAR goes directly to RUN.
  - WARM→RUN after `WARMUP` cycles.
  - RUN→ARGMAX, or RUN→DONE without the macro, after `STREAM_LEN` cycles.
  - ARGMAX→DONE after N2 cycles.
  - DONE→IDLE when `result_valid && result_ready`.
- Entering CLEAR zeroes all counters and `pred`.
- Outputs per state:
  - `net_clear` is high only in CLEAR.
  - `sng_en` is high in WARM and RUN.
  - Counters increment only in RUN: `counts[k] += net_dout[k]`, sampled each RUN cycle.
- Counter width CW holds STREAM_LEN exactly; counters never saturate and never wrap.
- `start` outside IDLE is ignored; it is not queued.
- `abort`, in any state other than IDLE, forces IDLE on the next edge:
  - clears the counters;
  - drops `net_clear` and `sng_en`;
  - produces no `result_valid`.
- `abort` and `start` in the same IDLE cycle: `abort` wins and the controller stays in IDLE.
- In DONE, `counts` and `pred` are stable and held until the handshake completes. They also hold after return to IDLE, until the next CLEAR.
- A `start` asserted in the same cycle as the DONE handshake is ignored. A new start requires the controller to be in IDLE.

## Timing
- All outputs are registered.
- Reset values: `busy=0`, `net_clear=0`, `sng_en=0`, `counts=0`, `pred=0`, `result_valid=0`; state = IDLE.
- A reset in the middle of an operation returns all outputs to these values immediately (asynchronously).
- Start sampled at edge 0 gives the following cycle timeline:
  - CLEAR: cycles 1..C, where C = CLR_CYCLES.
  - WARM: cycles C+1..C+W, where W = WARMUP.
  - RUN: cycles C+W+1..C+W+L, where L = STREAM_LEN.
  - `result_valid` first high at cycle C+W+L+1, or at C+W+L+N2+1 with the macro.
- `result_valid` stays high until the cycle after the handshake edge.

## Configuration
- `SC_CTRL_ARGMAX_EN` defined:
  - ARGMAX state present; one counter compared per cycle, k = 0..N2-1.
  - `pred` = index of the maximum count; ties go to the lowest index.
- Not defined:
  - no ARGMAX state; RUN goes directly to DONE.
  - `pred` is constant 0; latency is shortened by N2 cycles.

## Test plan
Bench parameters: N2=2, STREAM_LEN=8, WARMUP=2, CLR_CYCLES=2.
- Basic inference: `start` pulse with `net_dout` = 2'b01 constant, `result_ready` = 1.
  - `net_clear` high in cycles 1–2; `sng_en` high in cycles 3–12.
  - `counts` = {0, 8}.
  - `result_valid` at cycle 13, or 15 with the macro; `pred` = 0.
- Warm-up discard: `net_dout` = 2'b11 during WARM only, 0 during RUN → `counts` = {0, 0}.
- Argmax tie (macro on): class 0 gets 5 ones, class 1 gets 5 ones → `pred` = 0. Class 1 gets 6 ones → `pred` = 1.
- Back-pressure: `result_ready` = 0 for 20 cycles → `result_valid` and `counts` stable, `busy` = 1. A `start` pulse during this window is ignored. Ready = 1 → IDLE next cycle.
- Abort in RUN at cycle 7 → IDLE at cycle 8, `sng_en` = 0, `counts` = 0, no `result_valid`. A following `start` yields a full, correct inference.
- Async reset (`reset` = 0) in WARM → all outputs 0 immediately. After release, `start` gives the nominal timeline.
